// File: rtl/chess_move_pkg.sv
// Shared slot formats, piece codes and helpers for the move collector.
// Slot bus: eight 11-bit sliding/adjacent slots in the LSBs, then eight 8-bit knight slots.
package chess_move_pkg;

    localparam int NUM_SLOTS   = 16;
    localparam int NUM_SLIDE   = 8;
    localparam int SLOT_W      = 11;
    localparam int KSLOT_W     = 8;
    localparam int KNIGHT_BASE = NUM_SLIDE * SLOT_W;
    localparam int SLOT_BUS_W  = KNIGHT_BASE + NUM_SLIDE * KSLOT_W;

    localparam int SLOT_COLOR_BIT  = 10;
    localparam int SLOT_ORTH_BIT   = 9;
    localparam int SLOT_DIAG_BIT   = 8;
    localparam int SLOT_KING_BIT   = 7;
    localparam int SLOT_PAWN_BIT   = 6;
    localparam int KSLOT_COLOR_BIT = 7;

    localparam logic [SLOT_W-1:0]  EMPTY_MOVE        = '0;
    localparam logic [KSLOT_W-1:0] EMPTY_KNIGHT_MOVE = '0;

    localparam logic WHITE = 1'b1;
    localparam logic BLACK = 1'b0;

    typedef enum logic [2:0] {
        PC_PAWN   = 3'd0,
        PC_KNIGHT = 3'd1,
        PC_BISHOP = 3'd2,
        PC_ROOK   = 3'd3,
        PC_QUEEN  = 3'd4,
        PC_KING   = 3'd5
    } piece_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_LOAD,
        ST_EMIT
    } coll_state_e;

    // Knight slots are zero-extended so every slot can be handled as 11 bits.
    function automatic logic [SLOT_W-1:0] slot_of(input logic [SLOT_BUS_W-1:0] bus,
                                                  input logic [3:0] idx);
        logic [SLOT_W-1:0] s;
        if (idx[3] == 1'b0) begin
            s = bus[int'(idx[2:0]) * SLOT_W +: SLOT_W];
        end else begin
            s = {3'b000, bus[KNIGHT_BASE + int'(idx[2:0]) * KSLOT_W +: KSLOT_W]};
        end
        return s;
    endfunction

    function automatic logic slot_colour(input logic [3:0] idx, input logic [SLOT_W-1:0] s);
        return idx[3] ? s[KSLOT_COLOR_BIT] : s[SLOT_COLOR_BIT];
    endfunction

    function automatic piece_e decode_piece(input logic [3:0] idx, input logic [SLOT_W-1:0] s);
        piece_e p;
        if (idx[3])                                  p = PC_KNIGHT;
        else if (s[SLOT_PAWN_BIT])                   p = PC_PAWN;
        else if (s[SLOT_KING_BIT])                   p = PC_KING;
        else if (s[SLOT_ORTH_BIT] && s[SLOT_DIAG_BIT]) p = PC_QUEEN;
        else if (s[SLOT_ORTH_BIT])                   p = PC_ROOK;
        else                                         p = PC_BISHOP;
        return p;
    endfunction

    function automatic logic [NUM_SLOTS-1:0] build_mask(input logic [SLOT_BUS_W-1:0] bus,
                                                        input logic colour);
        logic [NUM_SLOTS-1:0] m;
        logic [SLOT_W-1:0]    s;
        m = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            s    = slot_of(bus, 4'(i));
            m[i] = (s != EMPTY_MOVE) && (slot_colour(4'(i), s) == colour);
        end
        return m;
    endfunction

endpackage

// File: rtl/move_collector_if.sv
// Registered move stream from the collector to the search/evaluation stage.
interface move_collector_if;
    import chess_move_pkg::*;

    logic       mv_valid;
    logic       mv_ready;
    logic [5:0] mv_from;
    logic [5:0] mv_to;
    piece_e     mv_piece;
    logic       mv_capture;
    logic       mv_promo;

    modport master (
        output mv_valid, mv_from, mv_to, mv_piece, mv_capture, mv_promo,
        input  mv_ready
    );

    modport slave (
        input  mv_valid, mv_from, mv_to, mv_piece, mv_capture, mv_promo,
        output mv_ready
    );
endinterface

// File: rtl/slot_prienc.sv
// Lowest-index-first priority encoder over the per-square slot mask; purely combinational.
module slot_prienc
    import chess_move_pkg::*;
(
    input  logic [NUM_SLOTS-1:0] mask_i,
    output logic [3:0]           idx_o,
    output logic                 any_o
);

    always_comb begin
        idx_o = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (mask_i[i]) idx_o = 4'(i);
        end
        any_o = |mask_i;
    end

endmodule

// File: rtl/move_collector.sv
// Walks squares 0..63 through the external mux and serialises own-colour moves onto a valid/ready stream.
// Empty squares cost 2 cycles; beats are registered and held stable while mv_ready is low.
module move_collector
    import chess_move_pkg::*;
#(
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  engine_color,
    output logic [5:0]            sq_sel,
    input  logic [SLOT_BUS_W-1:0] slot_bus,
    input  logic [5:0]            sq_piece,
    move_collector_if.master      mv,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      move_count
);

    localparam int SET_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

    coll_state_e           state_q, state_d;
    logic [SET_W-1:0]      settle_q, settle_d;
    logic [5:0]            sq_sel_q, sq_sel_d;
    logic [SLOT_BUS_W-1:0] slots_q, slots_d;
    logic                  cap_q, cap_d;
    logic [NUM_SLOTS-1:0]  mask_q, mask_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  vld_q, vld_d;
    logic [5:0]            from_q, from_d;
    logic [5:0]            to_q, to_d;
    piece_e                piece_q, piece_d;
    logic                  mcap_q, mcap_d;
    logic                  promo_q, promo_d;

    logic [3:0]        pe_idx;
    logic              pe_any;
    logic [SLOT_W-1:0] sel_slot;
    piece_e            sel_piece;
    logic              accept;

    slot_prienc u_prienc (
        .mask_i (mask_q),
        .idx_o  (pe_idx),
        .any_o  (pe_any)
    );

    assign sel_slot  = slot_of(slots_q, pe_idx);
    assign sel_piece = decode_piece(pe_idx, sel_slot);
    assign accept    = vld_q & mv.mv_ready;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        sq_sel_d = sq_sel_q;
        slots_d  = slots_q;
        cap_d    = cap_q;
        mask_d   = mask_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        vld_d    = vld_q;
        from_d   = from_q;
        to_d     = to_q;
        piece_d  = piece_q;
        mcap_d   = mcap_q;
        promo_d  = promo_q;

        if (accept && (cnt_q != '1)) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d    = '0;
                    settle_d = SET_W'(SETTLE_CYCLES);
                    busy_d   = 1'b1;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    sq_sel_d = '0;
                    state_d  = ST_LOAD;
                end else begin
                    settle_d = settle_q - SET_W'(1);
                end
            end
            ST_LOAD: begin
                slots_d = slot_bus;
                cap_d   = |sq_piece;
                mask_d  = build_mask(slot_bus, engine_color);
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                // Output register refills only when empty or its beat is leaving.
                if (!vld_q || accept) begin
                    if (pe_any) begin
                        vld_d          = 1'b1;
                        mask_d[pe_idx] = 1'b0;
                        from_d         = sel_slot[5:0];
                        to_d           = sq_sel_q;
                        piece_d        = sel_piece;
                        mcap_d         = cap_q;
                        promo_d        = (sel_piece == PC_PAWN) &&
                                         ((sq_sel_q[5:3] == 3'd0) || (sq_sel_q[5:3] == 3'd7));
                    end else begin
                        vld_d = 1'b0;
                        if (sq_sel_q == 6'd63) begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            sq_sel_d = sq_sel_q + 6'd1;
                            state_d  = ST_LOAD;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            sq_sel_q <= '0;
            slots_q  <= '0;
            cap_q    <= 1'b0;
            mask_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            vld_q    <= 1'b0;
            from_q   <= '0;
            to_q     <= '0;
            piece_q  <= PC_PAWN;
            mcap_q   <= 1'b0;
            promo_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            sq_sel_q <= sq_sel_d;
            slots_q  <= slots_d;
            cap_q    <= cap_d;
            mask_q   <= mask_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            vld_q    <= vld_d;
            from_q   <= from_d;
            to_q     <= to_d;
            piece_q  <= piece_d;
            mcap_q   <= mcap_d;
            promo_q  <= promo_d;
        end
    end

    assign sq_sel        = sq_sel_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign move_count    = cnt_q;
    assign mv.mv_valid   = vld_q;
    assign mv.mv_from    = from_q;
    assign mv.mv_to      = to_q;
    assign mv.mv_piece   = piece_q;
    assign mv.mv_capture = mcap_q;
    assign mv.mv_promo   = promo_q;

endmodule

// File: tb/tb_move_collector.sv
// Randomised and directed passes over a modelled board; expected beats queued by a reference model, checked by a monitor.
module tb_move_collector;
    import chess_move_pkg::*;

    localparam int SETTLE = 8;

    typedef struct packed {
        logic [5:0] from;
        logic [5:0] to;
        logic [2:0] piece;
        logic       cap;
        logic       promo;
    } beat_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         engine_color = 1'b1;
    logic [5:0]   sq_sel;
    logic [151:0] slot_bus;
    logic [5:0]   sq_piece;
    logic         busy, done;
    logic [7:0]   move_count;

    move_collector_if mv_bus ();

    move_collector #(.SETTLE_CYCLES(SETTLE), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .engine_color (engine_color),
        .sq_sel       (sq_sel),
        .slot_bus     (slot_bus),
        .sq_piece     (sq_piece),
        .mv           (mv_bus),
        .busy         (busy),
        .done         (done),
        .move_count   (move_count)
    );

    always #5 clk = ~clk;

    logic [10:0] sl [64][8];
    logic [7:0]  kn [64][8];
    logic [5:0]  pc [64];

    // Behavioural external 64:1 mux.
    always_comb begin
        slot_bus = '0;
        for (int i = 0; i < 8; i++) begin
            slot_bus[i*11 +: 11]     = sl[sq_sel][i];
            slot_bus[88 + i*8 +: 8]  = kn[sq_sel][i];
        end
        sq_piece = pc[sq_sel];
    end

    int    n_cmp = 0;
    int    n_fail = 0;
    beat_t exp_q[$];
    int    rdy_mode = 0;

    function automatic void check(string name, longint act, longint expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endfunction

    function automatic int sat(int n);
        return (n > 255) ? 255 : n;
    endfunction

    function automatic logic [2:0] ref_piece(logic [10:0] s);
        if (s[6])              return 3'd0;
        if (s[7])              return 3'd5;
        if (s[9] && s[8])      return 3'd4;
        if (s[9])              return 3'd3;
        return 3'd2;
    endfunction

    task automatic model_pass(input logic col);
        beat_t b;
        exp_q.delete();
        for (int sq = 0; sq < 64; sq++) begin
            for (int k = 0; k < 16; k++) begin
                logic [10:0] s;
                logic        c;
                s = (k < 8) ? sl[sq][k] : {3'b000, kn[sq][k-8]};
                c = (k < 8) ? s[10] : s[7];
                if (s != 0 && c == col) begin
                    b.from  = s[5:0];
                    b.to    = 6'(sq);
                    b.piece = (k < 8) ? ref_piece(s) : 3'd1;
                    b.cap   = (pc[sq] != 0);
                    b.promo = (b.piece == 3'd0) && ((sq / 8 == 0) || (sq / 8 == 7));
                    exp_q.push_back(b);
                end
            end
        end
    endtask

    task automatic clear_board();
        for (int sq = 0; sq < 64; sq++) begin
            pc[sq] = 0;
            for (int k = 0; k < 8; k++) begin
                sl[sq][k] = 0;
                kn[sq][k] = 0;
            end
        end
    endtask

    function automatic logic [10:0] rand_slide(logic col);
        logic [3:0] f;
        case ($urandom_range(0, 4))
            0:       f = 4'b0001;
            1:       f = 4'b0010;
            2:       f = 4'b1000;
            3:       f = 4'b0100;
            default: f = 4'b1100;
        endcase
        return {col, f, 6'($urandom_range(0, 63))};
    endfunction

    // colsel: 0 black only, 1 white only, 2 random
    task automatic rand_board(input int pct, input int colsel);
        logic c;
        for (int sq = 0; sq < 64; sq++) begin
            pc[sq] = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(1, 63)) : 6'd0;
            for (int k = 0; k < 8; k++) begin
                c = (colsel == 2) ? 1'($urandom_range(0, 1)) : 1'(colsel);
                sl[sq][k] = (int'($urandom_range(0, 99)) < pct) ? rand_slide(c) : 11'd0;
                c = (colsel == 2) ? 1'($urandom_range(0, 1)) : 1'(colsel);
                kn[sq][k] = (int'($urandom_range(0, 99)) < pct) ?
                            {c, 1'b0, 6'($urandom_range(0, 63))} : 8'd0;
            end
        end
    endtask

    // Monitor: drives mv_ready, pops the scoreboard on accepted beats, tracks hold and count.
    int    acc = 0;
    int    stall = 0;
    bit    prev_stall = 0;
    beat_t prev_b;
    always @(negedge clk) begin
        beat_t cur;
        beat_t e;
        logic  r;
        if (reset) begin
            acc = 0; stall = 0; prev_stall = 0;
            mv_bus.mv_ready = 1'b0;
        end else begin
            case (rdy_mode)
                0: r = 1'b1;
                1: r = 1'($urandom_range(0, 1));
                default: begin
                    if (mv_bus.mv_valid && stall < 5) begin r = 1'b0; stall++; end
                    else begin r = 1'b1; stall = 0; end
                end
            endcase
            mv_bus.mv_ready = r;
            cur = {mv_bus.mv_from, mv_bus.mv_to, 3'(mv_bus.mv_piece),
                   mv_bus.mv_capture, mv_bus.mv_promo};
            if (!busy) acc = 0;
            else check("move_count_live", move_count, sat(acc));
            if (mv_bus.mv_valid) begin
                if (prev_stall) check("hold_stable", cur, prev_b);
                if (r) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL unexpected_beat: got 0x%0h, expected none", cur);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", cur, e);
                    end
                    acc++;
                end
                prev_stall = !r;
                prev_b = cur;
            end else begin
                prev_stall = 0;
            end
        end
    end

    task automatic run_pass(input logic col, input int mode, input bit chk_time, input bit extra);
        int n_exp;
        int cyc;
        bit got;
        model_pass(col);
        n_exp = exp_q.size();
        engine_color = col;
        rdy_mode = mode;
        @(negedge clk);
        start = 1'b1;
        cyc = -1;
        got = 0;
        while (!got && cyc < 30000) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cyc == 0) start = 1'b0;
            if (extra && cyc == 60) start = 1'b1;
            if (extra && cyc == 61) start = 1'b0;
            if (done) got = 1;
        end
        start = 1'b0;
        check("done_seen", got, 1);
        if (got) begin
            if (chk_time) check("done_latency", cyc, SETTLE + 129);
            check("final_count", move_count, sat(n_exp));
            check("all_beats_seen", exp_q.size(), 0);
            @(negedge clk);
            check("done_one_cycle", done, 0);
            check("busy_after", busy, 0);
        end
    endtask

    initial begin
        int   cyc;
        bit   seen;
        clear_board();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sq_sel", sq_sel, 0);
        check("rst_valid", mv_bus.mv_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", move_count, 0);
        check("rst_fields", {mv_bus.mv_from, mv_bus.mv_to, 3'(mv_bus.mv_piece),
                             mv_bus.mv_capture, mv_bus.mv_promo}, 0);
        reset = 1'b0;

        // Empty board: timing of the minimum pass.
        run_pass(1'b1, 0, 1, 0);

        // Single white pawn push into square 20.
        clear_board();
        sl[20][0] = {1'b1, 4'b0001, 6'd12};
        run_pass(1'b1, 0, 0, 0);

        // Square 27: diagonal slider then knight, both capturing.
        clear_board();
        kn[27][0] = {1'b1, 1'b0, 6'd10};
        sl[27][7] = {1'b1, 4'b0100, 6'd0};
        pc[27] = 6'h05;
        run_pass(1'b1, 0, 0, 0);
        run_pass(1'b0, 0, 0, 0);

        // Back-pressure with promotion on the back rank.
        clear_board();
        sl[59][0] = {1'b1, 4'b0001, 6'd51};
        sl[59][3] = {1'b1, 4'b1000, 6'd63};
        run_pass(1'b1, 2, 0, 0);

        // Random boards and random ready.
        for (int t = 0; t < 4; t++) begin
            rand_board(15, 2);
            run_pass(1'($urandom_range(0, 1)), (t == 3) ? 2 : 1, 0, 1);
        end

        // Counter saturation: every slot occupied by the side to move.
        rand_board(100, 1);
        run_pass(1'b1, 0, 0, 0);

        // Reset while a beat is pending, then a clean full pass.
        rand_board(20, 1);
        model_pass(1'b1);
        engine_color = 1'b1;
        rdy_mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        cyc = 0;
        while (!seen && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (mv_bus.mv_valid) seen = 1;
        end
        check("valid_before_reset", seen, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_valid", mv_bus.mv_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_sq_sel", sq_sel, 0);
        check("midrst_count", move_count, 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        run_pass(1'b1, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/move_collector.md
Name: move_collector

Overview:
- Downstream of the 64 per-square transceiver stages.
- After a board position has been loaded and the move registers have settled, it walks squares 0..63 through an external 64:1 mux and reads each square's 16 registered move slots (8 sliding/adjacent, 8 knight).
- It drops slots that are empty or belong to the wrong colour, and serialises the remaining pseudo-legal moves onto a valid/ready stream for the search/evaluation stage.
- It reports completion and the total move count.

Parameters:
- SETTLE_CYCLES, 8, clocks waited after start so move propagation through the transceiver chain completes (7 hops plus 1 register).
- CNT_W, 8, width of the move counter; saturates at all-ones.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begin a generation pass (ignored unless IDLE)
- engine_color  in  1  side to move; 1 = white, 0 = black
- sq_sel  out  6  square currently selected on the external mux; registered
- slot_bus  in  152  selected square's *_move fields: [87:0] = U,D,L,R,UL,UR,DL,DR (11 b each, U in LSBs); [151:88] = UUL,UUR,LLU,RRU,DDL,DDR,LLD,RRD (8 b each)
- sq_piece  in  6  pieceReg of the selected square
- mv_valid  out  1  move beat valid
- mv_ready  in  1  consumer accepts beat
- mv_from  out  6  origin square (slot bits [5:0])
- mv_to  out  6  destination = sq_sel of the square that was loaded
- mv_piece  out  3  0 pawn, 1 knight, 2 bishop, 3 rook, 4 queen, 5 king
- mv_capture  out  1  sq_piece != 0 at load time
- mv_promo  out  1  pawn move landing on rank 0 or 7
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse at end of pass
- move_count  out  CNT_W  moves accepted in last/current pass

Behaviour:
- Slot formats (shared package):
  - 11-bit slot: [10] colour, [9] orthogonal slider, [8] diagonal slider, [7] king, [6] pawn, [5:0] origin.
  - 8-bit knight slot: [7] colour, [5:0] origin.
  - Empty slot = all zeros.
- Reset: state IDLE; sq_sel = 0; mv_valid = 0; busy = 0; done = 0; move_count = 0; mask = 0; all mv_* fields = 0.
- FSM:
  - IDLE: on start, clear move_count, load settle counter, set busy, go to SETTLE.
  - SETTLE: decrement counter; at 0, sq_sel = 0, go to LOAD. SETTLE_CYCLES = 0 goes straight to LOAD.
  - LOAD: sample slot_bus and sq_piece (the external mux is combinational from registered sq_sel, so data is valid that cycle). Set mask[i] = slot_i != 0 and slot_i colour == engine_color. Go to EMIT.
  - EMIT:
    - If mask == 0: if sq_sel == 63, go to IDLE, clear busy, pulse done; otherwise sq_sel + 1, go to LOAD.
    - Otherwise, present the lowest set slot index (priority order U..DR, then UUL..RRD) with mv_valid = 1. On mv_valid & mv_ready, clear that bit, increment move_count (saturating), and present the next slot the following cycle.
    - Up to one beat per cycle; mv_* fields stay stable while mv_valid & !mv_ready.
- Piece decode, first match wins:
  - knight slot → knight
  - [6] → pawn
  - [7] → king
  - [9] & [8] → queen
  - [9] → rook
  - [8] → bishop
- mv_promo = pawn & (mv_to[5:3] == 7 or 0).
- Timing: an empty square costs 2 cycles. The minimum pass is SETTLE_CYCLES + 1 (IDLE→SETTLE) + 128 cycles.
- mv_valid and all mv_* outputs are registered; no combinational path from mv_ready to mv_valid.
- start while busy: ignored. Reset mid-pass: immediate return to reset values; any in-flight beat is dropped.
- engine_color is sampled at each LOAD; it must be held stable for the whole pass.

Decomposition:
- Package chess_move_pkg:
  - slot bit-position constants
  - EMPTY_MOVE / EMPTY_KNIGHT_MOVE
  - WHITE / BLACK
  - piece-code enum
  - NUM_SLOTS = 16
- Sub-module slot_prienc: 16-bit mask → 4-bit index plus any-set flag; combinational, instanced once.

Test Plan:
- Empty board (slot_bus = 0 for all squares), start → no mv_valid; done pulses exactly SETTLE_CYCLES + 129 cycles after start; move_count = 0.
- Square 20 has U slot = {1,0,0,0,1,6'd12}, engine_color = 1, sq_piece = 0 → one beat: from 12, to 20, piece pawn, capture 0, promo 0; move_count = 1.
- Square 27 has UUL = {1,0,6'd10} and DR = {1,0,1,0,0,6'd0}, sq_piece = 6'h05 → two beats in order DR then UUL: (0→27 bishop, capture 1) then (10→27 knight, capture 1).
- Same square 27 stimulus with engine_color = 0 → both slots filtered; no beats.
- mv_ready held low 5 cycles during a beat → mv_* fields stable; count increments only on acceptance. Pawn slot from 51 at sq 59 → promo 1.
- reset asserted mid-EMIT with mv_valid high → next cycle mv_valid = 0, busy = 0, sq_sel = 0; a new start performs a full pass.
